// File: rtl/led_sink_scanner.sv
// led_sink_scanner
//   Sub-board row-sink scanner for an LED matrix. The main board marks every
//   row change with a transition on i_TOGGLE_SYNC and marks the start of a frame
//   with i_HEAD_FLAG. This block resynchronises both strobes and tracks the
//   current row. It drives a one-hot, break-before-make sink vector and flags
//   frame misalignment. A watchdog declares the sync stream lost when it stops.
//
// Ports
//   i_CLK          local scanner clock
//   i_RESET        asynchronous active-high reset
//   i_TOGGLE_SYNC  async row strobe; every edge is one row event
//   i_HEAD_FLAG    async frame-head marker, stable around the row-0 event
//   o_LED_SINK     one-hot row sink enable, all-zero while blanked
//   o_ROW_IDX      current row index
//   o_BLANK        high while all sinks are forced off
//   o_SYNC_LOST    high while the sync stream is considered lost
//   o_FRAME_ERR    one-cycle pulse on early or missing frame head
module led_sink_scanner #(
    parameter  int ROWS        = 32,
    parameter  int SYNC_STAGES = 2,
    parameter  int BLANK_CYC   = 4,
    parameter  int TIMEOUT_CYC = 65535,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            i_CLK,
    input  logic            i_RESET,
    input  logic            i_TOGGLE_SYNC,
    input  logic            i_HEAD_FLAG,
    output logic [ROWS-1:0] o_LED_SINK,
    output logic [RW-1:0]   o_ROW_IDX,
    output logic            o_BLANK,
    output logic            o_SYNC_LOST,
    output logic            o_FRAME_ERR
);

    localparam int             BW       = $clog2(BLANK_CYC + 1);
    localparam int             WW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [RW-1:0]  LAST_ROW = RW'(ROWS - 1);
    localparam logic [BW-1:0]  BLK_END  = BW'(BLANK_CYC - 1);
    localparam logic [WW-1:0]  WD_END   = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE, S_LOST} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] tog_sync_q, hd_sync_q;
    logic                   tog_prev_q, ev_q, hd_q;
    logic [RW-1:0]          row_q, row_d;
    logic [BW-1:0]          blk_q, blk_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic [ROWS-1:0]        sink_d;
    logic                   blank_d, lost_d, err_d;

    // Synchronisers plus edge detector. The event strobe and the head sample
    // are registered together so the head is always judged at its own event.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            tog_sync_q <= '0;
            hd_sync_q  <= '0;
            tog_prev_q <= 1'b0;
            ev_q       <= 1'b0;
            hd_q       <= 1'b0;
        end else begin
            tog_sync_q <= {tog_sync_q[SYNC_STAGES-2:0], i_TOGGLE_SYNC};
            hd_sync_q  <= {hd_sync_q[SYNC_STAGES-2:0], i_HEAD_FLAG};
            tog_prev_q <= tog_sync_q[SYNC_STAGES-1];
            ev_q       <= tog_sync_q[SYNC_STAGES-1] ^ tog_prev_q;
            hd_q       <= hd_sync_q[SYNC_STAGES-1];
        end
    end

    // State register; outputs are registered from their next-state values.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            blk_q       <= '0;
            wd_q        <= '0;
            o_LED_SINK  <= '0;
            o_BLANK     <= 1'b1;
            o_SYNC_LOST <= 1'b0;
            o_FRAME_ERR <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            blk_q       <= blk_d;
            wd_q        <= wd_d;
            o_LED_SINK  <= sink_d;
            o_BLANK     <= blank_d;
            o_SYNC_LOST <= lost_d;
            o_FRAME_ERR <= err_d;
        end
    end

    assign o_ROW_IDX = row_q;

    // Next-state logic. A row event always restarts blanking and the
    // watchdog, so it takes priority over a coincident watchdog expiry.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        blk_d   = blk_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE, S_LOST: begin
                // Only a frame head can (re)acquire the stream.
                if (ev_q && hd_q) begin
                    state_d = S_BLANK;
                    row_d   = '0;
                    blk_d   = '0;
                    wd_d    = '0;
                end
            end
            S_BLANK, S_DRIVE: begin
                if (ev_q) begin
                    state_d = S_BLANK;
                    blk_d   = '0;
                    wd_d    = '0;
                    if (hd_q || row_q == LAST_ROW) row_d = '0;
                    else                           row_d = row_q + RW'(1);
                end else if (wd_q == WD_END) begin
                    state_d = S_LOST;
                    row_d   = '0;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + WW'(1);
                    if (state_q == S_BLANK) begin
                        if (blk_q == BLK_END) state_d = S_DRIVE;
                        else                  blk_d   = blk_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, so sinks only ever light in DRIVE
    // and a row change always goes through BLANK first.
    always_comb begin
        sink_d  = (state_d == S_DRIVE) ? (ROWS'(1) << row_d) : '0;
        blank_d = (state_d != S_DRIVE);
        lost_d  = (state_d == S_LOST);
        // Alignment is only judged while locked; the acquiring head never flags.
        err_d   = ev_q && (state_q == S_BLANK || state_q == S_DRIVE) &&
                  (hd_q ? (row_q != LAST_ROW) : (row_q == LAST_ROW));
    end

endmodule

// File: tb/tb_led_sink_scanner.sv
module tb_led_sink_scanner;

    localparam int ROWS = 32;
    localparam int SS   = 2;
    localparam int BC   = 4;
    localparam int TO   = 100;
    localparam int LAT  = SS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        tog;
    logic        hd;
    logic [31:0] o_LED_SINK;
    logic [4:0]  o_ROW_IDX;
    logic        o_BLANK;
    logic        o_SYNC_LOST;
    logic        o_FRAME_ERR;

    led_sink_scanner #(
        .ROWS(ROWS), .SYNC_STAGES(SS), .BLANK_CYC(BC), .TIMEOUT_CYC(TO)
    ) dut (
        .i_CLK(clk), .i_RESET(rst), .i_TOGGLE_SYNC(tog), .i_HEAD_FLAG(hd),
        .o_LED_SINK(o_LED_SINK), .o_ROW_IDX(o_ROW_IDX), .o_BLANK(o_BLANK),
        .o_SYNC_LOST(o_SYNC_LOST), .o_FRAME_ERR(o_FRAME_ERR)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;

    // Reference model: input history per sampling edge, lock flag, row and
    // elapsed cycles since the last row event.
    logic hist_t [0:LAT+1];
    logic hist_h [0:LAT+1];
    bit   m_sync, m_lost, m_err;
    int   m_row, m_since;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 0; m_lost = 0; m_err = 0; m_row = 0; m_since = 0;
        for (int i = 0; i <= LAT + 1; i++) begin
            hist_t[i] = 1'b0;
            hist_h[i] = 1'b0;
        end
    endtask

    // Called once per rising edge with the inputs sampled at that edge.
    task automatic model_edge(input logic t, input logic h);
        bit ev, eh;
        for (int i = LAT + 1; i > 0; i--) begin
            hist_t[i] = hist_t[i-1];
            hist_h[i] = hist_h[i-1];
        end
        hist_t[0] = t;
        hist_h[0] = h;
        ev    = (hist_t[LAT] != hist_t[LAT+1]);
        eh    = hist_h[LAT];
        m_err = 0;
        if (ev) begin
            if (m_sync) begin
                m_err   = eh ? (m_row != ROWS - 1) : (m_row == ROWS - 1);
                m_row   = eh ? 0 : (m_row + 1) % ROWS;
                m_since = 0;
            end else if (eh) begin
                m_sync = 1; m_lost = 0; m_row = 0; m_since = 0;
            end
        end else if (m_sync) begin
            m_since++;
            if (m_since >= TO) begin
                m_sync = 0; m_lost = 1; m_row = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] es;
        es = (m_sync && m_since >= BC) ? (32'd1 << m_row) : 32'd0;
        chk("row_idx",   32'(o_ROW_IDX),   32'(m_row));
        chk("led_sink",  o_LED_SINK,       es);
        chk("blank",     32'(o_BLANK),     32'(es == 32'd0));
        chk("sync_lost", 32'(o_SYNC_LOST), 32'(m_lost));
        chk("frame_err", 32'(o_FRAME_ERR), 32'(m_err));
    endtask

    // One clock: drive after the falling edge, model at the rising edge,
    // check at the next falling edge.
    task automatic tick(input logic t, input logic h);
        tog = t;
        hd  = h;
        @(posedge clk);
        model_edge(t, h);
        @(negedge clk);
        check_model();
        if (o_FRAME_ERR === 1'b1) err_seen++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sink"}, o_LED_SINK, 32'd0);
        chk({tag, "_row"},  32'(o_ROW_IDX), 32'd0);
        chk({tag, "_blank"}, 32'(o_BLANK), 32'd1);
        chk({tag, "_lost"}, 32'(o_SYNC_LOST), 32'd0);
        chk({tag, "_err"},  32'(o_FRAME_ERR), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tog = 1'b0; hd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        bit          flip;
        bit          h;
        int          wait_c;
        int          e_row;
        logic [31:0] e_sink;
        bit          e_lost;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lat, gap;
        logic [31:0] sink_or;
        logic h;

        tbl[0] = '{1, 0, 20,  0, 32'h0, 0};   // idle: non-head events ignored
        tbl[1] = '{1, 0, 20,  0, 32'h0, 0};
        tbl[2] = '{1, 0, 20,  0, 32'h0, 0};
        tbl[3] = '{1, 1, 20,  0, 32'h1, 0};   // head acquires, row 0 driven
        tbl[4] = '{1, 0, 20,  1, 32'h2, 0};
        tbl[5] = '{1, 0, 20,  2, 32'h4, 0};
        tbl[6] = '{1, 1, 20,  0, 32'h1, 0};   // early head
        tbl[7] = '{0, 0, 120, 0, 32'h0, 1};   // stream stops -> lost
        tbl[8] = '{1, 0, 20,  0, 32'h0, 1};   // non-head ignored while lost
        tbl[9] = '{1, 1, 20,  0, 32'h1, 0};   // head recovers

        rst = 1'b1; tog = 1'b0; hd = 1'b0;
        model_reset();

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].flip ? ~tog : tog, tbl[i].h);
            repeat (tbl[i].wait_c) tick(tog, hd);
            chk($sformatf("tbl%0d_row", i),  32'(o_ROW_IDX), 32'(tbl[i].e_row));
            chk($sformatf("tbl%0d_sink", i), o_LED_SINK, tbl[i].e_sink);
            chk($sformatf("tbl%0d_lost", i), 32'(o_SYNC_LOST), 32'(tbl[i].e_lost));
        end

        // Head-to-sink latency from idle
        do_reset();
        repeat (3) begin
            tick(~tog, 1'b0);
            repeat (10) tick(tog, 1'b0);
        end
        tick(~tog, 1'b1);
        lat = 0;
        for (int n = 1; n <= 50; n++) begin
            tick(tog, hd);
            if (o_LED_SINK != 32'd0) begin
                lat = n;
                break;
            end
        end
        chk("head_to_sink_latency", 32'(lat), 32'(SS + 1 + BC));
        repeat (20) tick(tog, hd);

        // Full sweep of all rows, then wrap without head, then early head
        err_seen = 0;
        for (int r = 1; r < ROWS; r++) begin
            tick(~tog, 1'b0);
            repeat (20) tick(tog, 1'b0);
            chk($sformatf("sweep_row%0d", r), 32'(o_ROW_IDX), 32'(r));
            chk($sformatf("sweep_sink%0d", r), o_LED_SINK, 32'd1 << r);
        end
        chk("sweep_err_count", 32'(err_seen), 32'd0);
        err_seen = 0;
        tick(~tog, 1'b0);
        repeat (20) tick(tog, 1'b0);
        chk("wrap_err_count", 32'(err_seen), 32'd1);
        chk("wrap_row", 32'(o_ROW_IDX), 32'd0);
        for (int r = 1; r <= 10; r++) begin
            tick(~tog, 1'b0);
            repeat (20) tick(tog, 1'b0);
        end
        err_seen = 0;
        tick(~tog, 1'b1);
        repeat (20) tick(tog, 1'b1);
        chk("early_head_err_count", 32'(err_seen), 32'd1);
        chk("early_head_row", 32'(o_ROW_IDX), 32'd0);

        // Events two cycles apart keep sinks dark while the row tracks
        sink_or = '0;
        for (int i = 0; i < 20; i++) begin
            tick((i % 2 == 0) ? ~tog : tog, 1'b0);
            if (i >= 3) sink_or = sink_or | o_LED_SINK;
        end
        repeat (2) begin
            tick(tog, 1'b0);
            sink_or = sink_or | o_LED_SINK;
        end
        chk("burst_sink_off", sink_or, 32'd0);
        repeat (20) tick(tog, 1'b0);
        chk("burst_row", 32'(o_ROW_IDX), 32'd10);
        chk("burst_sink", o_LED_SINK, 32'd1 << 10);

        // Asynchronous reset in the middle of a drive phase
        @(negedge clk);
        #2;
        rst = 1'b1; tog = 1'b0; hd = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Randomized event stream against the model
        for (int e = 0; e < 150; e++) begin
            h = (e == 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
            repeat (3) tick(tog, h);
            tick(~tog, h);
            if (e == 5)                             gap = 96;  // event meets watchdog expiry
            else if ($urandom_range(0, 19) == 0)    gap = 94 + $urandom_range(0, 8);
            else                                    gap = $urandom_range(0, 20);
            repeat (gap) tick(tog, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sink_scanner.md
# led_sink_scanner

Sub-board row-sink scanner. It consumes the toggle-sync and head-flag strobes driven by the main LED array board. It resynchronises them into the local clock domain and drives a one-hot, break-before-make row-sink vector for the LED matrix. It also detects frame-alignment errors and loss of the sync stream.

## Interface
Parameters:
- ROWS, 32, number of sink rows (2..32); sets o_LED_SINK width
- SYNC_STAGES, 2, synchroniser flops on i_TOGGLE_SYNC and i_HEAD_FLAG (≥2)
- BLANK_CYC, 4, all-sinks-off cycles after every row event (≥1)
- TIMEOUT_CYC, 65535, cycles without a row event before sync is declared lost

Ports:
- i_CLK  in  1  local scanner clock
- i_RESET  in  1  asynchronous, active-high reset
- i_TOGGLE_SYNC  in  1  asynchronous to i_CLK; every transition (rise or fall) is one row event
- i_HEAD_FLAG  in  1  asynchronous to i_CLK; high around the event that starts a frame (row 0)
- o_LED_SINK  out  ROWS  one-hot active-high row sink enable; all-zero when blanked
- o_ROW_IDX  out  ceil(log2 ROWS)  current row index
- o_BLANK  out  1  high while all sinks are forced off
- o_SYNC_LOST  out  1  high while in LOST state
- o_FRAME_ERR  out  1  one-cycle pulse on frame misalignment

## Operation
- Both inputs pass through SYNC_STAGES-flop synchronisers. One extra register on synced toggle; XOR of the two gives the one-cycle event strobe `ev`. Synced head `hd` is sampled in the same cycle as `ev`.
- Row update on `ev`:
  - hd=1 → row := 0
  - hd=0 → row := row+1; ROWS-1 wraps to 0
- o_FRAME_ERR pulses in two cases:
  - `ev` with hd=1 while row ≠ ROWS-1 (early head)
  - `ev` with hd=0 while row = ROWS-1 (missing head; still wraps)
  - The first head after IDLE or LOST never flags.
- States:
  - IDLE (after reset): sinks off, o_BLANK=1. `ev` with hd=0 is ignored (row stays 0, no error). `ev` with hd=1 → BLANK, row 0.
  - BLANK: sinks off, o_BLANK=1, blank counter counts BLANK_CYC cycles, then → DRIVE. A new `ev` updates row and restarts the count.
  - DRIVE: o_LED_SINK = 1<<row, o_BLANK=0. `ev` → BLANK with updated row.
  - LOST: sinks off, o_BLANK=1, o_SYNC_LOST=1. `ev` with hd=0 is ignored. `ev` with hd=1 → BLANK, row 0, o_SYNC_LOST clears.
- Watchdog: runs in BLANK and DRIVE only, clears on every `ev`. When it reaches TIMEOUT_CYC → LOST, row := 0.
- Simultaneous `ev` and watchdog terminal count: `ev` wins; watchdog clears, no LOST.
- Sinks are never two-hot. A row change always passes through ≥ BLANK_CYC all-zero cycles.

## Timing
- Reset (async assert, sync release at next i_CLK edge) gives:
  - o_LED_SINK=0, o_ROW_IDX=0, o_BLANK=1, o_SYNC_LOST=0, o_FRAME_ERR=0, state IDLE
  - synchronisers and counters cleared
- Reset mid-frame: outputs drop to reset values immediately (asynchronously).
- i_TOGGLE_SYNC transition sampled at edge k:
  - `ev` high during cycle k+SYNC_STAGES
  - at edge k+SYNC_STAGES+1: o_ROW_IDX, o_BLANK=1, o_LED_SINK=0, o_FRAME_ERR registered
  - one-hot sink asserts at edge k+SYNC_STAGES+1+BLANK_CYC
- i_HEAD_FLAG must be stable ≥ SYNC_STAGES+1 cycles around each toggle transition. Events closer than BLANK_CYC+1 cycles apart keep the sinks off; the row still tracks.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Reset, then toggle with head=1, then 31 toggles with head=0, ≥20 cycles apart → o_ROW_IDX steps 0..31, o_LED_SINK=0x00000001..0x80000000, each preceded by 4 blank cycles, no FRAME_ERR.
- In IDLE, 3 toggles with head=0 → sinks stay 0, row 0, no error. Then head toggle → row 0 driven 2+1+4 cycles later.
- Head at row 10 → one FRAME_ERR pulse, row 0. At row 31, toggle without head → FRAME_ERR, row wraps to 0.
- Toggle stream stops (TIMEOUT_CYC=100): after 100 idle cycles → o_SYNC_LOST=1, sinks 0. A non-head toggle is ignored; a head toggle recovers with o_SYNC_LOST=0, row 0.
- Toggles 2 cycles apart → o_LED_SINK stays 0, row increments each event. Assert reset mid-DRIVE → all outputs return to reset values before the next clock edge.
